// File: rtl/axi_mem_responder_if.sv
// AXI4 bus bundle between the MacTile axiSlv_0 master port and a memory responder.
// Signal names follow the flattened axiSlv_<channel>_<field> naming of the master.
interface axi_mem_responder_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32
);
    logic                  aw_valid;
    logic                  aw_ready;
    logic [ID_WIDTH-1:0]   aw_bits_id;
    logic [ADDR_WIDTH-1:0] aw_bits_addr;
    logic [7:0]            aw_bits_len;
    logic [2:0]            aw_bits_size;
    logic [1:0]            aw_bits_burst;

    logic                  w_valid;
    logic                  w_ready;
    logic [63:0]           w_bits_data;
    logic [7:0]            w_bits_strb;
    logic                  w_bits_last;

    logic                  b_valid;
    logic                  b_ready;
    logic [ID_WIDTH-1:0]   b_bits_id;
    logic [1:0]            b_bits_resp;

    logic                  ar_valid;
    logic                  ar_ready;
    logic [ID_WIDTH-1:0]   ar_bits_id;
    logic [ADDR_WIDTH-1:0] ar_bits_addr;
    logic [7:0]            ar_bits_len;
    logic [2:0]            ar_bits_size;
    logic [1:0]            ar_bits_burst;

    logic                  r_valid;
    logic                  r_ready;
    logic [ID_WIDTH-1:0]   r_bits_id;
    logic [63:0]           r_bits_data;
    logic [1:0]            r_bits_resp;
    logic                  r_bits_last;

    modport master (
        output aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
        input  aw_ready,
        output w_valid, w_bits_data, w_bits_strb, w_bits_last,
        input  w_ready,
        input  b_valid, b_bits_id, b_bits_resp,
        output b_ready,
        output ar_valid, ar_bits_id, ar_bits_addr, ar_bits_len, ar_bits_size, ar_bits_burst,
        input  ar_ready,
        input  r_valid, r_bits_id, r_bits_data, r_bits_resp, r_bits_last,
        output r_ready
    );

    modport slave (
        input  aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
        output aw_ready,
        input  w_valid, w_bits_data, w_bits_strb, w_bits_last,
        output w_ready,
        output b_valid, b_bits_id, b_bits_resp,
        input  b_ready,
        input  ar_valid, ar_bits_id, ar_bits_addr, ar_bits_len, ar_bits_size, ar_bits_burst,
        output ar_ready,
        output r_valid, r_bits_id, r_bits_data, r_bits_resp, r_bits_last,
        input  r_ready
    );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI4 slave backed by a 64-bit on-chip word memory; independent write and read FSMs,
// one outstanding burst per direction, INCR/FIXED bursts of up to 256 beats.
module axi_mem_responder #(
    parameter int                    ID_WIDTH    = 4,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
    parameter int                    DEPTH_WORDS = 4096
) (
    input logic                clock,
    input logic                reset,
    axi_mem_responder_if.slave axiSlv
);
    localparam int                    IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_WIDTH-1:0] SPAN  = ADDR_WIDTH'(DEPTH_WORDS * 8);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // ---------------- write path ----------------
    w_state_t              w_state_reg, w_state_next;
    logic                  aw_ready_reg, aw_ready_next;
    logic                  w_ready_reg, w_ready_next;
    logic                  b_valid_reg, b_valid_next;
    logic [ID_WIDTH-1:0]   w_id_reg;
    logic [ADDR_WIDTH-1:0] w_addr_reg;
    logic [7:0]            w_len_reg;
    logic                  w_incr_reg;
    logic                  w_legal_reg;
    logic                  w_err_reg;
    logic [8:0]            w_beat_reg;

    logic                  aw_hs, w_hs, b_hs;
    logic [ADDR_WIDTH-1:0] w_off;
    logic                  w_ok;
    logic                  mem_we;
    logic [IDX_W-1:0]      w_idx;

    assign aw_hs  = axiSlv.aw_valid & aw_ready_reg;
    assign w_hs   = axiSlv.w_valid & w_ready_reg;
    assign b_hs   = b_valid_reg & axiSlv.b_ready;
    assign w_off  = w_addr_reg - BASE_ADDR;
    assign w_idx  = w_off[IDX_W+2:3];
    assign w_ok   = w_legal_reg && (w_off < SPAN);
    assign mem_we = (w_state_reg == W_DATA) && w_hs && w_ok;

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && axiSlv.w_bits_last) w_state_next = W_RESP;
            W_RESP:  if (b_hs) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
        // Handshake outputs are registered from the next state so they read 0 in reset.
        aw_ready_next = (w_state_next == W_IDLE);
        w_ready_next  = (w_state_next == W_DATA);
        b_valid_next  = (w_state_next == W_RESP);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            w_state_reg  <= W_IDLE;
            aw_ready_reg <= 1'b0;
            w_ready_reg  <= 1'b0;
            b_valid_reg  <= 1'b0;
            w_id_reg     <= '0;
            w_addr_reg   <= '0;
            w_len_reg    <= '0;
            w_incr_reg   <= 1'b0;
            w_legal_reg  <= 1'b0;
            w_err_reg    <= 1'b0;
            w_beat_reg   <= '0;
        end else begin
            w_state_reg  <= w_state_next;
            aw_ready_reg <= aw_ready_next;
            w_ready_reg  <= w_ready_next;
            b_valid_reg  <= b_valid_next;
            if (w_state_reg == W_IDLE && aw_hs) begin
                w_id_reg    <= axiSlv.aw_bits_id;
                w_addr_reg  <= axiSlv.aw_bits_addr;
                w_len_reg   <= axiSlv.aw_bits_len;
                w_incr_reg  <= (axiSlv.aw_bits_burst == 2'd1);
                w_legal_reg <= (axiSlv.aw_bits_size == 3'd3) && !axiSlv.aw_bits_burst[1];
                w_err_reg   <= 1'b0;
                w_beat_reg  <= '0;
            end
            if (w_state_reg == W_DATA && w_hs) begin
                if (!w_ok)
                    w_err_reg <= 1'b1;
                if (axiSlv.w_bits_last && (w_beat_reg != {1'b0, w_len_reg}))
                    w_err_reg <= 1'b1;
                if (w_beat_reg != '1)
                    w_beat_reg <= w_beat_reg + 9'd1;
                if (w_incr_reg)
                    w_addr_reg <= w_addr_reg + ADDR_WIDTH'(8);
            end
        end
    end

    assign axiSlv.aw_ready    = aw_ready_reg;
    assign axiSlv.w_ready     = w_ready_reg;
    assign axiSlv.b_valid     = b_valid_reg;
    assign axiSlv.b_bits_id   = w_id_reg;
    assign axiSlv.b_bits_resp = w_err_reg ? 2'b10 : 2'b00;

    // ---------------- read path ----------------
    r_state_t              r_state_reg, r_state_next;
    logic                  ar_ready_reg, ar_ready_next;
    logic                  r_valid_reg, r_valid_next;
    logic [ID_WIDTH-1:0]   r_id_reg;
    logic [ADDR_WIDTH-1:0] r_addr_reg;
    logic [7:0]            r_len_reg;
    logic [7:0]            r_beat_reg;
    logic                  r_incr_reg;
    logic                  r_legal_reg;
    logic                  r_last_reg;
    logic [1:0]            r_resp_reg;
    logic                  data_ok_reg;

    logic                  ar_hs, r_hs;
    logic                  fetch_en;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic [7:0]            fetch_beat;
    logic [7:0]            fetch_len;
    logic                  fetch_incr;
    logic                  fetch_legal;
    logic [ADDR_WIDTH-1:0] fetch_off;
    logic                  fetch_ok;
    logic [IDX_W-1:0]      fetch_idx;
    logic                  mem_re;
    logic [63:0]           rd_word;

    assign ar_hs = axiSlv.ar_valid & ar_ready_reg;
    assign r_hs  = r_valid_reg & axiSlv.r_ready;

    always_comb begin
        r_state_next = r_state_reg;
        fetch_en     = 1'b0;
        fetch_addr   = r_incr_reg ? (r_addr_reg + ADDR_WIDTH'(8)) : r_addr_reg;
        fetch_beat   = r_beat_reg + 8'd1;
        fetch_len    = r_len_reg;
        fetch_incr   = r_incr_reg;
        fetch_legal  = r_legal_reg;
        case (r_state_reg)
            R_IDLE: begin
                fetch_en    = ar_hs;
                fetch_addr  = axiSlv.ar_bits_addr;
                fetch_beat  = 8'd0;
                fetch_len   = axiSlv.ar_bits_len;
                fetch_incr  = (axiSlv.ar_bits_burst == 2'd1);
                fetch_legal = (axiSlv.ar_bits_size == 3'd3) && !axiSlv.ar_bits_burst[1];
                if (ar_hs) r_state_next = R_DATA;
            end
            R_DATA: begin
                // Next beat is fetched on the accepting edge to sustain one beat per cycle.
                fetch_en = r_hs && !r_last_reg;
                if (r_hs && r_last_reg) r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
        ar_ready_next = (r_state_next == R_IDLE);
        r_valid_next  = (r_state_next == R_DATA);
    end

    assign fetch_off = fetch_addr - BASE_ADDR;
    assign fetch_idx = fetch_off[IDX_W+2:3];
    assign fetch_ok  = fetch_legal && (fetch_off < SPAN);
    assign mem_re    = fetch_en && fetch_ok;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state_reg  <= R_IDLE;
            ar_ready_reg <= 1'b0;
            r_valid_reg  <= 1'b0;
            r_id_reg     <= '0;
            r_addr_reg   <= '0;
            r_len_reg    <= '0;
            r_beat_reg   <= '0;
            r_incr_reg   <= 1'b0;
            r_legal_reg  <= 1'b0;
            r_last_reg   <= 1'b0;
            r_resp_reg   <= 2'b00;
            data_ok_reg  <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            ar_ready_reg <= ar_ready_next;
            r_valid_reg  <= r_valid_next;
            if (r_state_reg == R_IDLE && ar_hs)
                r_id_reg <= axiSlv.ar_bits_id;
            if (fetch_en) begin
                r_addr_reg  <= fetch_addr;
                r_len_reg   <= fetch_len;
                r_beat_reg  <= fetch_beat;
                r_incr_reg  <= fetch_incr;
                r_legal_reg <= fetch_legal;
                r_last_reg  <= (fetch_beat == fetch_len);
                r_resp_reg  <= fetch_ok ? 2'b00 : 2'b10;
                data_ok_reg <= fetch_ok;
            end
        end
    end

    // Byte-lane memory; read-before-write on a same-edge collision.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH_WORDS];
            logic [7:0] lane_rd_reg;
            always_ff @(posedge clock) begin
                if (mem_we && axiSlv.w_bits_strb[gi])
                    lane_mem[w_idx] <= axiSlv.w_bits_data[gi*8 +: 8];
                if (mem_re)
                    lane_rd_reg <= lane_mem[fetch_idx];
            end
            assign rd_word[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

    assign axiSlv.ar_ready    = ar_ready_reg;
    assign axiSlv.r_valid     = r_valid_reg;
    assign axiSlv.r_bits_id   = r_id_reg;
    assign axiSlv.r_bits_data = data_ok_reg ? rd_word : 64'd0;
    assign axiSlv.r_bits_resp = r_resp_reg;
    assign axiSlv.r_bits_last = r_last_reg;
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder: writes, readbacks, errors,
// B back-pressure, R stalls and asynchronous reset mid-burst.
module tb_axi_mem_responder;
    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    axi_mem_responder_if #(.ID_WIDTH(4), .ADDR_WIDTH(32)) axiSlv ();

    axi_mem_responder #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (32'h8000_0000),
        .DEPTH_WORDS(4096)
    ) dut (
        .clock (clock),
        .reset (reset),
        .axiSlv(axiSlv)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        axiSlv.aw_valid      = 1'b1;
        axiSlv.aw_bits_id    = id;
        axiSlv.aw_bits_addr  = addr;
        axiSlv.aw_bits_len   = len;
        axiSlv.aw_bits_burst = burst;
        axiSlv.aw_bits_size  = size;
        while (axiSlv.aw_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("aw_accept", 64'(n < 50), 64'd1);
        @(negedge clock);
        axiSlv.aw_valid = 1'b0;
        $display("AW id=%0h addr=%h len=%0d burst=%0d size=%0d", id, addr, len, burst, size);
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        axiSlv.w_valid     = 1'b1;
        axiSlv.w_bits_data = data;
        axiSlv.w_bits_strb = strb;
        axiSlv.w_bits_last = last;
        while (axiSlv.w_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("w_accept", 64'(n < 50), 64'd1);
        @(negedge clock);
        axiSlv.w_valid = 1'b0;
        $display("W  data=%h strb=%h last=%0b", data, strb, last);
    endtask

    task automatic wait_b(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int n = 0;
        axiSlv.b_ready = 1'b1;
        while (axiSlv.b_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_bvalid"}, 64'(axiSlv.b_valid), 64'd1);
        check({tag, "_bid"}, 64'(axiSlv.b_bits_id), 64'(id));
        check({tag, "_bresp"}, 64'(axiSlv.b_bits_resp), 64'(resp));
        $display("B  id=%0h resp=%0d", axiSlv.b_bits_id, axiSlv.b_bits_resp);
        @(negedge clock);
        axiSlv.b_ready = 1'b0;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [2:0] size);
        int n = 0;
        axiSlv.ar_valid      = 1'b1;
        axiSlv.ar_bits_id    = id;
        axiSlv.ar_bits_addr  = addr;
        axiSlv.ar_bits_len   = len;
        axiSlv.ar_bits_burst = burst;
        axiSlv.ar_bits_size  = size;
        while (axiSlv.ar_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("ar_accept", 64'(n < 50), 64'd1);
        @(negedge clock);
        axiSlv.ar_valid = 1'b0;
        $display("AR id=%0h addr=%h len=%0d burst=%0d size=%0d", id, addr, len, burst, size);
    endtask

    // Expects the beat to be valid already (no bubble), then accepts it.
    task automatic rbeat(input string tag, input logic [63:0] data, input logic [1:0] resp,
                         input logic last, input logic [3:0] id);
        int n = 0;
        axiSlv.r_ready = 1'b1;
        while (axiSlv.r_valid !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_rwait"}, 64'(n), 64'd0);
        check({tag, "_rdata"}, axiSlv.r_bits_data, data);
        check({tag, "_rresp"}, 64'(axiSlv.r_bits_resp), 64'(resp));
        check({tag, "_rlast"}, 64'(axiSlv.r_bits_last), 64'(last));
        check({tag, "_rid"}, 64'(axiSlv.r_bits_id), 64'(id));
        $display("R  id=%0h data=%h resp=%0d last=%0b", axiSlv.r_bits_id, axiSlv.r_bits_data,
                 axiSlv.r_bits_resp, axiSlv.r_bits_last);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0;
        axiSlv.aw_valid = 0; axiSlv.aw_bits_id = 0; axiSlv.aw_bits_addr = 0;
        axiSlv.aw_bits_len = 0; axiSlv.aw_bits_size = 0; axiSlv.aw_bits_burst = 0;
        axiSlv.w_valid = 0; axiSlv.w_bits_data = 0; axiSlv.w_bits_strb = 0; axiSlv.w_bits_last = 0;
        axiSlv.b_ready = 0;
        axiSlv.ar_valid = 0; axiSlv.ar_bits_id = 0; axiSlv.ar_bits_addr = 0;
        axiSlv.ar_bits_len = 0; axiSlv.ar_bits_size = 0; axiSlv.ar_bits_burst = 0;
        axiSlv.r_ready = 0;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_readies", {61'd0, axiSlv.aw_ready, axiSlv.w_ready, axiSlv.ar_ready}, 64'd0);
        check("rst_valids", {62'd0, axiSlv.b_valid, axiSlv.r_valid}, 64'd0);
        check("rst_rdata", axiSlv.r_bits_data, 64'd0);
        check("rst_ids_resp", {50'd0, axiSlv.r_bits_last, axiSlv.r_bits_resp, axiSlv.b_bits_resp,
                               axiSlv.b_bits_id, axiSlv.r_bits_id}, 64'd0);
        reset = 1'b1;

        // Single-beat write and readback
        send_aw(4'h3, 32'h8000_0010, 8'd0, 2'd1, 3'd3);
        send_w(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
        wait_b("t1", 4'h3, 2'b00);
        send_ar(4'h5, 32'h8000_0010, 8'd0, 2'd1, 3'd3);
        rbeat("t1", 64'h1122_3344_5566_7788, 2'b00, 1'b1, 4'h5);
        axiSlv.r_ready = 1'b0;

        // Partial strobe overwrite
        send_aw(4'h6, 32'h8000_0010, 8'd0, 2'd1, 3'd3);
        send_w(64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 1'b1);
        wait_b("t2", 4'h6, 2'b00);
        send_ar(4'h6, 32'h8000_0010, 8'd0, 2'd1, 3'd3);
        rbeat("t2", 64'h1122_3344_FFFF_FFFF, 2'b00, 1'b1, 4'h6);
        axiSlv.r_ready = 1'b0;

        // INCR burst write, full-throughput read
        send_aw(4'h1, 32'h8000_0100, 8'd3, 2'd1, 3'd3);
        for (int i = 0; i < 4; i++) send_w(64'(i + 1), 8'hFF, (i == 3));
        wait_b("t3", 4'h1, 2'b00);
        send_ar(4'h2, 32'h8000_0100, 8'd3, 2'd1, 3'd3);
        for (int i = 0; i < 4; i++) rbeat("t3", 64'(i + 1), 2'b00, (i == 3), 4'h2);
        axiSlv.r_ready = 1'b0;

        // Same read with alternating r_ready: data must hold across stalls
        send_ar(4'h2, 32'h8000_0100, 8'd3, 2'd1, 3'd3);
        for (int i = 0; i < 4; i++) begin
            axiSlv.r_ready = 1'b0;
            @(negedge clock);
            check("t3s_valid", 64'(axiSlv.r_valid), 64'd1);
            check("t3s_data", axiSlv.r_bits_data, 64'(i + 1));
            check("t3s_last", 64'(axiSlv.r_bits_last), 64'(i == 3));
            axiSlv.r_ready = 1'b1;
            @(negedge clock);
        end
        axiSlv.r_ready = 1'b0;
        check("t3s_done_valid", 64'(axiSlv.r_valid), 64'd0);
        check("t3s_done_arready", 64'(axiSlv.ar_ready), 64'd1);

        // Out-of-range write and read
        send_aw(4'h7, 32'h9000_0000, 8'd1, 2'd1, 3'd3);
        send_w(64'hAAAA, 8'hFF, 1'b0);
        send_w(64'hBBBB, 8'hFF, 1'b1);
        wait_b("t4", 4'h7, 2'b10);
        send_ar(4'h7, 32'h9000_0000, 8'd1, 2'd1, 3'd3);
        rbeat("t4a", 64'd0, 2'b10, 1'b0, 4'h7);
        rbeat("t4b", 64'd0, 2'b10, 1'b1, 4'h7);
        axiSlv.r_ready = 1'b0;

        // Early w_last: beat count shorter than len+1
        send_aw(4'h8, 32'h8000_0200, 8'd1, 2'd1, 3'd3);
        send_w(64'h55, 8'hFF, 1'b1);
        wait_b("t5", 4'h8, 2'b10);

        // FIXED burst: both beats land on the same word
        send_aw(4'h9, 32'h8000_0300, 8'd1, 2'd0, 3'd3);
        send_w(64'hA1, 8'hFF, 1'b0);
        send_w(64'hB2, 8'hFF, 1'b1);
        wait_b("t6", 4'h9, 2'b00);
        send_ar(4'h9, 32'h8000_0300, 8'd1, 2'd0, 3'd3);
        rbeat("t6a", 64'hB2, 2'b00, 1'b0, 4'h9);
        rbeat("t6b", 64'hB2, 2'b00, 1'b1, 4'h9);
        axiSlv.r_ready = 1'b0;

        // Illegal size on a read
        send_ar(4'h4, 32'h8000_0010, 8'd0, 2'd1, 3'd2);
        rbeat("t6c", 64'd0, 2'b10, 1'b1, 4'h4);
        axiSlv.r_ready = 1'b0;

        // B back-pressure with a pending AW
        send_aw(4'hA, 32'h8000_0400, 8'd0, 2'd1, 3'd3);
        send_w(64'h77, 8'hFF, 1'b1);
        axiSlv.aw_valid = 1'b1; axiSlv.aw_bits_id = 4'hB; axiSlv.aw_bits_addr = 32'h8000_0408;
        axiSlv.aw_bits_len = 8'd0; axiSlv.aw_bits_burst = 2'd1; axiSlv.aw_bits_size = 3'd3;
        for (int i = 0; i < 5; i++) begin
            check("t7_bvalid_hold", 64'(axiSlv.b_valid), 64'd1);
            check("t7_awready_low", 64'(axiSlv.aw_ready), 64'd0);
            @(negedge clock);
        end
        wait_b("t7a", 4'hA, 2'b00);
        check("t7_awready_after_b", 64'(axiSlv.aw_ready), 64'd1);
        send_aw(4'hB, 32'h8000_0408, 8'd0, 2'd1, 3'd3);
        send_w(64'h88, 8'hFF, 1'b1);
        wait_b("t7b", 4'hB, 2'b00);
        send_ar(4'h1, 32'h8000_0400, 8'd1, 2'd1, 3'd3);
        rbeat("t7c", 64'h77, 2'b00, 1'b0, 4'h1);
        rbeat("t7d", 64'h88, 2'b00, 1'b1, 4'h1);
        axiSlv.r_ready = 1'b0;

        // Asynchronous reset during beat 2 of a len-7 read
        send_ar(4'hC, 32'h8000_0100, 8'd7, 2'd1, 3'd3);
        rbeat("t8", 64'd1, 2'b00, 1'b0, 4'hC);
        check("t8_beat2", axiSlv.r_bits_data, 64'd2);
        reset = 1'b0;
        #1;
        check("t8_rst_rvalid", 64'(axiSlv.r_valid), 64'd0);
        check("t8_rst_arready", 64'(axiSlv.ar_ready), 64'd0);
        check("t8_rst_rdata", axiSlv.r_bits_data, 64'd0);
        axiSlv.r_ready = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t8_arready", 64'(axiSlv.ar_ready), 64'd1);
        check("t8_rvalid_idle", 64'(axiSlv.r_valid), 64'd0);
        send_ar(4'hD, 32'h8000_0010, 8'd0, 2'd1, 3'd3);
        rbeat("t8r", 64'h1122_3344_FFFF_FFFF, 2'b00, 1'b1, 4'hD);
        axiSlv.r_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
